dmem_seq_ctrl: RTL and testbench
================================

DMEM_SEQ_CTRL -- requirements
Module: dmem_seq_ctrl

Interface
REQ-001 SHALL have parameter AddrDMEM, default 8, DMem address width.
REQ-002 SHALL have parameter LenW, default 4, burst-length field width (length = len+1 beats).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports v_req/h_req  in  1  vertical/horizontal requester command valid, held until ack.
REQ-006 SHALL have ports v_wr/h_wr  in  1  command type: 1 write to DMem, 0 read from DMem.
REQ-007 SHALL have ports v_base/h_base  in  AddrDMEM  burst start address.
REQ-008 SHALL have ports v_len/h_len  in  LenW  beats minus one.
REQ-009 SHALL have ports v_ack/h_ack  out  1  one-cycle command-accept pulse.
REQ-010 SHALL have port we_ram  out  1  DMem write enable.
REQ-011 SHALL have ports sel_ram_i/sel_ram_o  out  2  DMem input/output steering: 2'b10 vertical, 2'b11 horizontal, 2'b00 none.
REQ-012 SHALL have ports w_addr/r_addr  out  AddrDMEM  DMem write/read address.
REQ-013 SHALL have ports busy  out  1  burst in progress; done  out  1  one-cycle pulse on last beat.

Function
REQ-014 SHALL implement FSM IDLE, RUN; IDLE->RUN on grant; RUN->IDLE after beat len; at most one grant per IDLE cycle.
REQ-015 In IDLE with any req, SHALL grant one requester, pulse its ack in the same cycle, and latch wr/base/len/owner on that edge.
REQ-016 Simultaneous v_req and h_req SHALL be granted to the requester not granted last (round-robin); after reset V has priority.
REQ-017 In RUN SHALL issue one beat per cycle; beat k address = base+k modulo 2^AddrDMEM (wrap from max address to 0).
REQ-018 Write beat: we_ram=1, w_addr=beat address, sel_ram_i=owner code, sel_ram_o=2'b00, r_addr=0.
REQ-019 Read beat: we_ram=0, r_addr=beat address, sel_ram_o=owner code, sel_ram_i=2'b00, w_addr=0.
REQ-020 First beat SHALL occur the cycle after ack; burst of len+1 beats occupies exactly len+1 RUN cycles.
REQ-021 done SHALL be 1 during the last beat cycle; busy SHALL be 1 for every RUN cycle.
REQ-022 Return to IDLE costs one cycle; next grant earliest in the cycle after done (back-to-back bursts separated by one idle cycle).
REQ-023 Requests arriving during RUN SHALL be ignored (no ack) until IDLE; latched command SHALL not change mid-burst.
REQ-024 In IDLE all outputs SHALL be 0 except ack of a granted requester.

Reset
REQ-025 rst low SHALL immediately force IDLE, all outputs 0, beat counter 0, round-robin pointer to V, independent of clk.
REQ-026 rst asserted mid-burst SHALL abort it with no further we_ram; no done pulse SHALL be produced for the aborted burst.
REQ-027 After rst deasserts, first grant SHALL occur no earlier than the first clk edge with rst high.

Configuration
REQ-028 With macro DMEM_SEQ_CTRL_PERF_CNT_EN defined, SHALL add output beat_cnt, 16 bits, counting issued beats, saturating at 16'hFFFF, reset to 0.
REQ-029 Without DMEM_SEQ_CTRL_PERF_CNT_EN, beat_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 V write base=8'h10 len=3 -> v_ack 1 cycle; next 4 cycles we_ram=1, w_addr 10,11,12,13, sel_ram_i=2'b10; done on 4th; then IDLE.
REQ-031 H read base=8'hFE len=3 -> r_addr FE,FF,00,01, sel_ram_o=2'b11, we_ram=0 throughout.
REQ-032 v_req and h_req both high from reset, len=0 each -> grant order V,H,V,H; ack spacing 3 cycles.
REQ-033 h_req asserted during V burst of len=7 -> no h_ack until cycle after done; H burst then runs.
REQ-034 rst pulled low on beat 2 of write len=5 -> we_ram drops to 0 asynchronously, no done, next grant goes to V.
REQ-035 With DMEM_SEQ_CTRL_PERF_CNT_EN: bursts len=3 then len=0 -> beat_cnt=5; preloaded near saturation -> holds 16'hFFFF.

Source files
------------

// File: rtl/dmem_seq_ctrl.sv
// DMem burst sequencer: arbitrates vertical/horizontal requesters and issues one DMem beat per cycle.
// Latency: ack in the same cycle as grant, first beat the next cycle; one return cycle after done before the next grant.
// Backpressure: requesters hold req until ack; requests seen during a burst are not acknowledged until the sequencer is idle.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   v_*/h_*                  requester command: req, wr (1 = write DMem), base address, len (beats - 1), ack pulse
//   we_ram, w_addr, r_addr   DMem write enable and write/read addresses
//   sel_ram_i/sel_ram_o      DMem input/output steering: 2'b10 vertical, 2'b11 horizontal, 2'b00 none
//   busy, done               burst in progress / last-beat pulse
//   beat_cnt                 saturating issued-beat counter, present only with DMEM_SEQ_CTRL_PERF_CNT_EN defined
module dmem_seq_ctrl #(
  parameter int AddrDMEM = 8,
  parameter int LenW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                v_req,
  input  logic                v_wr,
  input  logic [AddrDMEM-1:0] v_base,
  input  logic [LenW-1:0]     v_len,
  input  logic                h_req,
  input  logic                h_wr,
  input  logic [AddrDMEM-1:0] h_base,
  input  logic [LenW-1:0]     h_len,
  output logic                v_ack,
  output logic                h_ack,
  output logic                we_ram,
  output logic [1:0]          sel_ram_i,
  output logic [1:0]          sel_ram_o,
  output logic [AddrDMEM-1:0] w_addr,
  output logic [AddrDMEM-1:0] r_addr,
  output logic                busy,
  output logic                done
`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]         beat_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] SEL_V    = 2'b10;
  localparam logic [1:0] SEL_H    = 2'b11;
  localparam logic [1:0] SEL_NONE = 2'b00;

  state_t              state;
  logic                wr_q;
  logic                own_h_q;
  logic                prio_h_q;     // 1: H wins the next tie
  logic                idle_hold_q;  // blocks grant in the return cycle and the first cycle after reset
  logic [AddrDMEM-1:0] addr_q;
  logic [LenW-1:0]     len_q;
  logic [LenW-1:0]     cnt_q;

  logic                can_grant;
  logic                gnt_v;
  logic                gnt_h;
  logic                sel_wr;
  logic [AddrDMEM-1:0] sel_base;
  logic [LenW-1:0]     sel_len;
  logic [1:0]          gnt_code;
  logic [1:0]          own_code;
  logic [AddrDMEM-1:0] addr_nxt;
  logic [LenW-1:0]     cnt_nxt;

  // Round-robin between the two requesters; only one can win per idle cycle.
  assign can_grant = (state == S_IDLE) && !idle_hold_q;
  assign gnt_v     = can_grant && v_req && (!h_req || !prio_h_q);
  assign gnt_h     = can_grant && h_req && (!v_req ||  prio_h_q);
  assign v_ack     = gnt_v;
  assign h_ack     = gnt_h;

  assign sel_wr   = gnt_h ? h_wr   : v_wr;
  assign sel_base = gnt_h ? h_base : v_base;
  assign sel_len  = gnt_h ? h_len  : v_len;
  assign gnt_code = gnt_h ? SEL_H  : SEL_V;
  assign own_code = own_h_q ? SEL_H : SEL_V;

  // Address wraps naturally at 2^AddrDMEM.
  assign addr_nxt = addr_q + AddrDMEM'(1);
  assign cnt_nxt  = cnt_q + LenW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      own_h_q     <= 1'b0;
      prio_h_q    <= 1'b0;
      idle_hold_q <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      we_ram      <= 1'b0;
      sel_ram_i   <= SEL_NONE;
      sel_ram_o   <= SEL_NONE;
      w_addr      <= '0;
      r_addr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          idle_hold_q <= 1'b0;
          if (gnt_v || gnt_h) begin
            // Latch the command and present beat 0 on the same edge.
            state     <= S_RUN;
            wr_q      <= sel_wr;
            own_h_q   <= gnt_h;
            prio_h_q  <= gnt_v;
            addr_q    <= sel_base;
            len_q     <= sel_len;
            cnt_q     <= '0;
            busy      <= 1'b1;
            done      <= (sel_len == '0);
            we_ram    <= sel_wr;
            sel_ram_i <= sel_wr ? gnt_code : SEL_NONE;
            sel_ram_o <= sel_wr ? SEL_NONE : gnt_code;
            w_addr    <= sel_wr ? sel_base : '0;
            r_addr    <= sel_wr ? '0 : sel_base;
          end
        end
        S_RUN: begin
          if (cnt_q == len_q) begin
            state       <= S_IDLE;
            idle_hold_q <= 1'b1;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            we_ram      <= 1'b0;
            sel_ram_i   <= SEL_NONE;
            sel_ram_o   <= SEL_NONE;
            w_addr      <= '0;
            r_addr      <= '0;
          end else begin
            cnt_q  <= cnt_nxt;
            addr_q <= addr_nxt;
            done   <= (cnt_nxt == len_q);
            w_addr <= wr_q ? addr_nxt : '0;
            r_addr <= wr_q ? '0 : addr_nxt;
            // Steering stays on the latched owner for the whole burst.
            sel_ram_i <= wr_q ? own_code : SEL_NONE;
            sel_ram_o <= wr_q ? SEL_NONE : own_code;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
  // busy is high for exactly one cycle per issued beat.
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
    end else if (busy && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Directed bench for dmem_seq_ctrl: reset, write/read bursts with wrap, round-robin, busy-ignore, reset abort.
// Outputs sampled 1 ns after the rising edge; inputs driven at the same point.
// Requesters hold req until the ack pulse is observed.
module tb_dmem_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       v_req, v_wr, h_req, h_wr;
  logic [7:0] v_base, h_base;
  logic [3:0] v_len, h_len;
  logic       v_ack, h_ack, we_ram, busy, done;
  logic [1:0] sel_ram_i, sel_ram_o;
  logic [7:0] w_addr, r_addr;
`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
  logic [15:0] beat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_seq_ctrl #(.AddrDMEM(8), .LenW(4)) dut (
    .clk(clk), .rst(rst),
    .v_req(v_req), .v_wr(v_wr), .v_base(v_base), .v_len(v_len),
    .h_req(h_req), .h_wr(h_wr), .h_base(h_base), .h_len(h_len),
    .v_ack(v_ack), .h_ack(h_ack), .we_ram(we_ram),
    .sel_ram_i(sel_ram_i), .sel_ram_o(sel_ram_o),
    .w_addr(w_addr), .r_addr(r_addr), .busy(busy), .done(done)
`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    v_req = 0; v_wr = 0; v_base = 0; v_len = 0;
    h_req = 0; h_wr = 0; h_base = 0; h_len = 0;
    repeat (2) @(posedge clk);
    #1;
    v_req = 1; h_req = 1;
    #1;
    n_cmp++; if (v_ack !== 1'b0) begin n_bad++; $display("FAIL rst_v_ack got=%b exp=0", v_ack); end
    n_cmp++; if (h_ack !== 1'b0) begin n_bad++; $display("FAIL rst_h_ack got=%b exp=0", h_ack); end
    n_cmp++; if ({busy, done, we_ram} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, we_ram}); end
    n_cmp++; if ({sel_ram_i, sel_ram_o, w_addr, r_addr} !== 20'h0) begin n_bad++; $display("FAIL rst_bus got=%h exp=0", {sel_ram_i, sel_ram_o, w_addr, r_addr}); end
    v_req = 0; h_req = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_v_write();
    logic [7:0] exp_a;
    tick();
    v_wr = 1; v_base = 8'h10; v_len = 4'd3; v_req = 1;
    #1;
    n_cmp++; if ({v_ack, h_ack} !== 2'b10) begin n_bad++; $display("FAIL vw_ack got=%b exp=10", {v_ack, h_ack}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL vw_busy_ackcyc got=%b exp=0", busy); end
    tick();
    v_req = 0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      exp_a = 8'h10 + 8'(k);
      n_cmp++; if ({we_ram, busy} !== 2'b11) begin n_bad++; $display("FAIL vw_we_busy k=%0d got=%b exp=11", k, {we_ram, busy}); end
      n_cmp++; if (w_addr !== exp_a) begin n_bad++; $display("FAIL vw_waddr k=%0d got=%h exp=%h", k, w_addr, exp_a); end
      n_cmp++; if ({sel_ram_i, sel_ram_o, r_addr} !== {2'b10, 2'b00, 8'h00}) begin n_bad++; $display("FAIL vw_sel k=%0d got=%h exp=%h", k, {sel_ram_i, sel_ram_o, r_addr}, {2'b10, 2'b00, 8'h00}); end
      n_cmp++; if (done !== (k == 3)) begin n_bad++; $display("FAIL vw_done k=%0d got=%b exp=%b", k, done, (k == 3)); end
    end
    tick();
    n_cmp++; if ({busy, done, we_ram, sel_ram_i, w_addr} !== 13'h0) begin n_bad++; $display("FAIL vw_idle got=%h exp=0", {busy, done, we_ram, sel_ram_i, w_addr}); end
  endtask

  task automatic test_h_read_wrap();
    logic [7:0] tbl [4];
    tbl[0] = 8'hFE; tbl[1] = 8'hFF; tbl[2] = 8'h00; tbl[3] = 8'h01;
    tick();
    h_wr = 0; h_base = 8'hFE; h_len = 4'd3; h_req = 1;
    #1;
    n_cmp++; if ({v_ack, h_ack} !== 2'b01) begin n_bad++; $display("FAIL hr_ack got=%b exp=01", {v_ack, h_ack}); end
    tick();
    h_req = 0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      n_cmp++; if (r_addr !== tbl[k]) begin n_bad++; $display("FAIL hr_raddr k=%0d got=%h exp=%h", k, r_addr, tbl[k]); end
      n_cmp++; if ({we_ram, sel_ram_o, sel_ram_i, w_addr} !== {1'b0, 2'b11, 2'b00, 8'h00}) begin n_bad++; $display("FAIL hr_ctl k=%0d got=%h exp=%h", k, {we_ram, sel_ram_o, sel_ram_i, w_addr}, {1'b0, 2'b11, 2'b00, 8'h00}); end
      n_cmp++; if (done !== (k == 3)) begin n_bad++; $display("FAIL hr_done k=%0d got=%b exp=%b", k, done, (k == 3)); end
    end
    tick();
    n_cmp++; if ({busy, sel_ram_o, r_addr} !== 11'h0) begin n_bad++; $display("FAIL hr_idle got=%h exp=0", {busy, sel_ram_o, r_addr}); end
  endtask

  task automatic test_round_robin();
    int  ack_cyc [8];
    logic ack_h  [8];
    int  n_ack = 0;
    int  exp_cyc [4];
    logic exp_h  [4];
    exp_cyc[0] = 0; exp_cyc[1] = 3; exp_cyc[2] = 6; exp_cyc[3] = 9;
    exp_h[0] = 0; exp_h[1] = 1; exp_h[2] = 0; exp_h[3] = 1;
    tick();
    rst = 1'b0;
    #1;
    v_wr = 0; v_base = 8'h30; v_len = 0;
    h_wr = 0; h_base = 8'h50; h_len = 0;
    v_req = 1; h_req = 1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (v_ack && h_ack) begin
        n_cmp++; n_bad++; $display("FAIL rr_dual_ack cyc=%0d got=11 exp=one-hot", c);
      end
      if ((v_ack || h_ack) && n_ack < 8) begin
        ack_cyc[n_ack] = c;
        ack_h[n_ack]   = h_ack;
        n_ack++;
      end
    end
    v_req = 0; h_req = 0;
    n_cmp++;
    if (n_ack < 4) begin
      n_bad++; $display("FAIL rr_ack_count got=%0d exp>=4", n_ack);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (ack_h[i] !== exp_h[i]) begin n_bad++; $display("FAIL rr_order i=%0d got_h=%b exp_h=%b", i, ack_h[i], exp_h[i]); end
        n_cmp++; if (ack_cyc[i] != exp_cyc[i]) begin n_bad++; $display("FAIL rr_cycle i=%0d got=%0d exp=%0d", i, ack_cyc[i], exp_cyc[i]); end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp_a;
    tick();
    v_wr = 1; v_base = 8'h40; v_len = 4'd7; v_req = 1;
    #1;
    n_cmp++; if (v_ack !== 1'b1) begin n_bad++; $display("FAIL bi_v_ack got=%b exp=1", v_ack); end
    tick();
    v_req = 0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) tick();
      if (k == 2) begin
        h_wr = 0; h_base = 8'h80; h_len = 4'd1; h_req = 1;
        v_base = 8'hAA; v_len = 4'd0;
      end
      #1;
      exp_a = 8'h40 + 8'(k);
      n_cmp++; if (h_ack !== 1'b0) begin n_bad++; $display("FAIL bi_h_ack_run k=%0d got=%b exp=0", k, h_ack); end
      n_cmp++; if (w_addr !== exp_a) begin n_bad++; $display("FAIL bi_waddr k=%0d got=%h exp=%h", k, w_addr, exp_a); end
      n_cmp++; if (done !== (k == 7)) begin n_bad++; $display("FAIL bi_done k=%0d got=%b exp=%b", k, done, (k == 7)); end
    end
    tick();
    n_cmp++; if ({h_ack, busy} !== 2'b00) begin n_bad++; $display("FAIL bi_return_cyc got=%b exp=00", {h_ack, busy}); end
    tick();
    n_cmp++; if ({v_ack, h_ack} !== 2'b01) begin n_bad++; $display("FAIL bi_h_grant got=%b exp=01", {v_ack, h_ack}); end
    tick();
    h_req = 0;
    n_cmp++; if ({r_addr, sel_ram_o, we_ram, done} !== {8'h80, 2'b11, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bi_h_beat0 got=%h exp=%h", {r_addr, sel_ram_o, we_ram, done}, {8'h80, 2'b11, 1'b0, 1'b0}); end
    tick();
    n_cmp++; if ({r_addr, sel_ram_o, done} !== {8'h81, 2'b11, 1'b1}) begin n_bad++; $display("FAIL bi_h_beat1 got=%h exp=%h", {r_addr, sel_ram_o, done}, {8'h81, 2'b11, 1'b1}); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp_a;
    tick();
    v_wr = 1; v_base = 8'h20; v_len = 4'd5; v_req = 1;
    #1;
    n_cmp++; if (v_ack !== 1'b1) begin n_bad++; $display("FAIL ra_v_ack got=%b exp=1", v_ack); end
    tick();
    v_req = 0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      exp_a = 8'h20 + 8'(k);
      n_cmp++; if ({we_ram, w_addr} !== {1'b1, exp_a}) begin n_bad++; $display("FAIL ra_beat k=%0d got=%h exp=%h", k, {we_ram, w_addr}, {1'b1, exp_a}); end
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if ({we_ram, busy, done, sel_ram_i, w_addr} !== 13'h0) begin n_bad++; $display("FAIL ra_async_clear got=%h exp=0", {we_ram, busy, done, sel_ram_i, w_addr}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({we_ram, done} !== 2'b00) begin n_bad++; $display("FAIL ra_held c=%0d got=%b exp=00", c, {we_ram, done}); end
    end
    v_wr = 0; v_base = 8'h60; v_len = 0;
    h_wr = 0; h_base = 8'h70; h_len = 0;
    v_req = 1; h_req = 1;
    #1;
    n_cmp++; if ({v_ack, h_ack} !== 2'b00) begin n_bad++; $display("FAIL ra_ack_in_rst got=%b exp=00", {v_ack, h_ack}); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if ({v_ack, h_ack} !== 2'b10) begin n_bad++; $display("FAIL ra_first_grant got=%b exp=10", {v_ack, h_ack}); end
    tick();
    v_req = 0; h_req = 0;
    n_cmp++; if ({r_addr, sel_ram_o, done} !== {8'h60, 2'b10, 1'b1}) begin n_bad++; $display("FAIL ra_v_beat got=%h exp=%h", {r_addr, sel_ram_o, done}, {8'h60, 2'b10, 1'b1}); end
    tick();
  endtask

`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
  task automatic run_v_burst(input logic [3:0] len);
    tick();
    v_wr = 1; v_base = 8'h00; v_len = len; v_req = 1;
    tick();
    v_req = 0;
    repeat (int'(len) + 2) tick();
  endtask

  task automatic test_perf_cnt();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (beat_cnt !== 16'h0) begin n_bad++; $display("FAIL pc_reset got=%h exp=0000", beat_cnt); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_v_burst(4'd3);
    run_v_burst(4'd0);
    n_cmp++; if (beat_cnt !== 16'd5) begin n_bad++; $display("FAIL pc_count got=%0d exp=5", beat_cnt); end
    force dut.beat_cnt_q = 16'hFFFD;
    #1;
    release dut.beat_cnt_q;
    run_v_burst(4'd3);
    n_cmp++; if (beat_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL pc_saturate got=%h exp=ffff", beat_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_v_write();
    test_h_read_wrap();
    test_round_robin();
    test_busy_ignore();
    test_reset_abort();
`ifdef DMEM_SEQ_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
